// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter
//   Shares a single-port cache between NUM_REQ requesters. Idle requests are
//   arbitrated round-robin. The winner's address is latched, and a one-cycle
//   search pulse is issued. The address is held until the cache reports done
//   or the wait times out. The response is then returned to the winner.
//   Saturating hit/miss statistics are kept.
//
// Ports
//   clock              rising-edge system clock
//   reset              asynchronous, active-low; clears all state and outputs
//   req_valid          per-requester request
//   req_addr           requester i address at [i*ADDR_W +: ADDR_W]
//   req_ready          one-hot accept strobe (combinational, IDLE only)
//   resp_valid         one-hot response strobe to the transaction owner
//   resp_hit           hit flag of the last response
//   resp_error         last response was a timeout
//   resp_data          data of the last response
//   cache_search       one-cycle search pulse to the cache
//   cache_address      address presented to the cache, held between transactions
//   cache_search_done  cache lookup finished (only honoured while waiting)
//   cache_hit          cache hit flag
//   cache_data         cache read data
//   hit_count          completed hits, saturating
//   miss_count         completed misses, saturating

module cache_req_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic                        resp_hit,
  output logic                        resp_error,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        cache_search,
  output logic [ADDR_W-1:0]           cache_address,
  input  logic                        cache_search_done,
  input  logic                        cache_hit,
  input  logic [DATA_W-1:0]           cache_data,
  output logic [CNT_W-1:0]            hit_count,
  output logic [CNT_W-1:0]            miss_count
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [PTR_W-1:0]    rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0]    owner, owner_d;
  logic [WCNT_W-1:0]   wait_cnt, wait_cnt_d;
  logic [ADDR_W-1:0]   cache_address_d;
  logic                cache_search_d;
  logic [NUM_REQ-1:0]  resp_valid_d;
  logic [DATA_W-1:0]   resp_data_d;
  logic                resp_hit_d;
  logic                resp_error_d;
  logic [CNT_W-1:0]    hit_count_d;
  logic [CNT_W-1:0]    miss_count_d;

  logic                grant_found;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    cand;
  logic [ADDR_W-1:0]   grant_addr;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Address of the selected requester.
  always_comb begin
    grant_addr = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (PTR_W'(k) == grant_idx) begin
        grant_addr = req_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state;
    rr_ptr_d        = rr_ptr;
    owner_d         = owner;
    wait_cnt_d      = wait_cnt;
    cache_address_d = cache_address;
    cache_search_d  = 1'b0;
    resp_valid_d    = '0;
    resp_data_d     = resp_data;
    resp_hit_d      = resp_hit;
    resp_error_d    = resp_error;
    hit_count_d     = hit_count;
    miss_count_d    = miss_count;
    req_ready       = '0;

    case (state)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          owner_d              = grant_idx;
          cache_address_d      = grant_addr;
          cache_search_d       = 1'b1;
          rr_ptr_d             = (32'(grant_idx) == NUM_REQ - 1) ? '0
                                                                 : grant_idx + PTR_W'(1);
          state_d              = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        // A done on the final wait cycle takes priority over the timeout.
        if (cache_search_done) begin
          resp_data_d         = cache_data;
          resp_hit_d          = cache_hit;
          resp_error_d        = 1'b0;
          resp_valid_d[owner] = 1'b1;
          if (cache_hit) begin
            if (hit_count != '1) hit_count_d = hit_count + CNT_W'(1);
          end else begin
            if (miss_count != '1) miss_count_d = miss_count + CNT_W'(1);
          end
          state_d = S_RESP;
        end else if (wait_cnt == WCNT_W'(TIMEOUT_CYCLES - 1)) begin
          resp_data_d         = '0;
          resp_hit_d          = 1'b0;
          resp_error_d        = 1'b1;
          resp_valid_d[owner] = 1'b1;
          state_d             = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt + WCNT_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accept strobe is forced low while reset is asserted.
    if (!reset) req_ready = '0;
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      wait_cnt      <= '0;
      cache_address <= '0;
      cache_search  <= 1'b0;
      resp_valid    <= '0;
      resp_data     <= '0;
      resp_hit      <= 1'b0;
      resp_error    <= 1'b0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      state         <= state_d;
      rr_ptr        <= rr_ptr_d;
      owner         <= owner_d;
      wait_cnt      <= wait_cnt_d;
      cache_address <= cache_address_d;
      cache_search  <= cache_search_d;
      resp_valid    <= resp_valid_d;
      resp_data     <= resp_data_d;
      resp_hit      <= resp_hit_d;
      resp_error    <= resp_error_d;
      hit_count     <= hit_count_d;
      miss_count    <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Testbench for cache_req_arbiter: transaction-level reference model,
// per-cycle output comparison, and directed scenarios with literal checks.

module tb_cache_req_arbiter;

  localparam int NUM_REQ        = 2;
  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 64;
  localparam int TIMEOUT_CYCLES = 32;
  localparam int CNT_W          = 16;
  localparam longint CNT_MAX    = (longint'(1) << CNT_W) - 1;

  logic                       clock;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         resp_valid;
  logic                       resp_hit;
  logic                       resp_error;
  logic [DATA_W-1:0]          resp_data;
  logic                       cache_search;
  logic [ADDR_W-1:0]          cache_address;
  logic                       cache_search_done;
  logic                       cache_hit;
  logic [DATA_W-1:0]          cache_data;
  logic [CNT_W-1:0]           hit_count;
  logic [CNT_W-1:0]           miss_count;

  cache_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_error(resp_error),
    .resp_data(resp_data), .cache_search(cache_search),
    .cache_address(cache_address), .cache_search_done(cache_search_done),
    .cache_hit(cache_hit), .cache_data(cache_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- cache responder ----------------
  int              delay_cfg = 0;   // cycles from search to done; 0 = never
  logic            hit_cfg   = 1'b0;
  logic [63:0]     data_cfg  = '0;
  logic            done_r    = 1'b0;
  logic            stale_done = 1'b0;
  int              cd        = 0;

  assign cache_search_done = done_r | stale_done;
  assign cache_hit         = hit_cfg;
  assign cache_data        = data_cfg;

  initial begin
    forever begin
      @(negedge clock);
      if (reset && cache_search && delay_cfg > 0) cd = delay_cfg;
      @(posedge clock);
      #1;
      done_r = 1'b0;
      if (!reset) cd = 0;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) done_r = 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  // Tracks one transaction by cycle numbers: accept cycle, response cycle.
  function automatic int win(input logic [NUM_REQ-1:0] v, input int ptr);
    int i;
    for (int k = 0; k < NUM_REQ; k++) begin
      i = (ptr + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input int i);
    return ADDR_W'(req_addr >> (i * ADDR_W));
  endfunction

  bit                 m_pending = 1'b0;
  bit                 m_decided = 1'b0;
  int                 m_ptr = 0, m_owner = 0, m_acc = -100, m_resp_cyc = -1;
  logic [ADDR_W-1:0]  m_addr = '0;
  logic [DATA_W-1:0]  m_data = '0;
  bit                 m_hit = 1'b0, m_err = 1'b0;
  longint             m_hits = 0, m_misses = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pending  <= 1'b0;
      m_decided  <= 1'b0;
      m_ptr      <= 0;
      m_owner    <= 0;
      m_acc      <= -100;
      m_resp_cyc <= -1;
      m_addr     <= '0;
      m_data     <= '0;
      m_hit      <= 1'b0;
      m_err      <= 1'b0;
      m_hits     <= 0;
      m_misses   <= 0;
    end else if (!m_pending) begin
      if (|req_valid) begin
        m_owner   <= win(req_valid, m_ptr);
        m_addr    <= addr_of(win(req_valid, m_ptr));
        m_ptr     <= (win(req_valid, m_ptr) + 1) % NUM_REQ;
        m_acc     <= cyc;
        m_pending <= 1'b1;
        m_decided <= 1'b0;
      end
    end else begin
      if (!m_decided && cyc >= m_acc + 2) begin
        if (cache_search_done) begin
          m_decided  <= 1'b1;
          m_resp_cyc <= cyc + 1;
          m_data     <= cache_data;
          m_hit      <= cache_hit;
          m_err      <= 1'b0;
          if (cache_hit) begin
            if (m_hits < CNT_MAX) m_hits <= m_hits + 1;
          end else begin
            if (m_misses < CNT_MAX) m_misses <= m_misses + 1;
          end
        end else if (cyc == m_acc + 1 + TIMEOUT_CYCLES) begin
          m_decided  <= 1'b1;
          m_resp_cyc <= cyc + 1;
          m_data     <= '0;
          m_hit      <= 1'b0;
          m_err      <= 1'b1;
        end
      end
      if (m_decided && cyc == m_resp_cyc) m_pending <= 1'b0;
    end
  end

  // ---------------- per-cycle compare + event log ----------------
  logic [NUM_REQ-1:0] exp_ready, exp_rv;
  logic               exp_search;
  int                 search_count = 0, ready_events = 0, resp_events = 0;
  int                 last_search_cyc = -1;
  logic [ADDR_W-1:0]  last_search_addr = '0;

  initial begin
    forever begin
      @(negedge clock);
      exp_ready = '0;
      if (reset && !m_pending && |req_valid) exp_ready = onehot(win(req_valid, m_ptr));
      exp_search = m_pending && (cyc == m_acc + 1);
      exp_rv = (m_pending && m_decided && cyc == m_resp_cyc) ? onehot(m_owner) : '0;
      chk("req_ready",     64'(req_ready),     64'(exp_ready));
      chk("cache_search",  64'(cache_search),  64'(exp_search));
      chk("resp_valid",    64'(resp_valid),    64'(exp_rv));
      chk("cache_address", 64'(cache_address), 64'(m_addr));
      chk("resp_data",     64'(resp_data),     64'(m_data));
      chk("resp_hit",      64'(resp_hit),      64'(m_hit));
      chk("resp_error",    64'(resp_error),    64'(m_err));
      chk("hit_count",     64'(hit_count),     64'(m_hits));
      chk("miss_count",    64'(miss_count),    64'(m_misses));
      if (cache_search) begin
        search_count++;
        last_search_cyc  = cyc;
        last_search_addr = cache_address;
      end
      if (|req_ready)  ready_events++;
      if (|resp_valid) resp_events++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output int t, output int idx);
    bit seen;
    seen = 1'b0;
    t = -1;
    idx = -1;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clock);
      if (|req_ready) begin
        seen = 1'b1;
        t = cyc;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) idx = i;
      end
    end
    if (!seen) chk("grant_wait_expired", 64'(0), 64'(1));
  endtask

  task automatic wait_resp(output int r);
    bit seen;
    seen = 1'b0;
    r = -1;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clock);
      if (|resp_valid) begin
        seen = 1'b1;
        r = cyc;
      end
    end
    if (!seen) chk("resp_wait_expired", 64'(0), 64'(1));
  endtask

  int t, g, r, e0, s0;
  int order [4];

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_addr  = '0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_search",  64'(cache_search),  64'(0));
    chk("rst_rv",      64'(resp_valid),    64'(0));
    chk("rst_addr",    64'(cache_address), 64'(0));
    chk("rst_hits",    64'(hit_count),     64'(0));
    tick();
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle_no_ready",  64'(ready_events), 64'(0));
    chk("idle_no_search", 64'(search_count), 64'(0));

    // Hit: req0 addr 0, done 2 cycles after search
    tick();
    req_addr[0 +: ADDR_W] = 32'd0;
    req_valid = 2'b01;
    delay_cfg = 2;
    hit_cfg   = 1'b1;
    data_cfg  = 64'h0123_4567_89ab_cdef;
    wait_ready(t, g);
    chk("hit_grant", 64'(g), 64'(0));
    tick();
    req_valid = '0;
    wait_resp(r);
    chk("hit_search_lat", 64'(last_search_cyc - t), 64'(1));
    chk("hit_search_addr", 64'(last_search_addr), 64'(0));
    chk("hit_resp_lat", 64'(r - t), 64'(4));
    chk("hit_rv",       64'(resp_valid), 64'(2'b01));
    chk("hit_flag",     64'(resp_hit),   64'(1));
    chk("hit_data",     resp_data,       64'h0123_4567_89ab_cdef);
    chk("hit_cnt1",     64'(hit_count),  64'(1));

    // Miss: req1 addr 16, done 8 cycles after search, data 256
    tick();
    req_addr[ADDR_W +: ADDR_W] = 32'd16;
    req_valid = 2'b10;
    delay_cfg = 8;
    hit_cfg   = 1'b0;
    data_cfg  = 64'd256;
    wait_ready(t, g);
    chk("miss_grant", 64'(g), 64'(1));
    tick();
    req_valid = '0;
    wait_resp(r);
    chk("miss_resp_lat", 64'(r - t), 64'(10));
    chk("miss_rv",       64'(resp_valid), 64'(2'b10));
    chk("miss_data",     resp_data,       64'd256);
    chk("miss_flag",     64'(resp_hit),   64'(0));
    chk("miss_cnt1",     64'(miss_count), 64'(1));
    chk("miss_addr",     64'(cache_address), 64'(16));

    // Fairness: both held for four transactions
    tick();
    req_addr[0 +: ADDR_W]      = 32'd16;
    req_addr[ADDR_W +: ADDR_W] = 32'd24;
    req_valid = 2'b11;
    delay_cfg = 1;
    hit_cfg   = 1'b1;
    data_cfg  = 64'd5;
    s0 = search_count;
    for (int n = 0; n < 4; n++) begin
      wait_ready(t, g);
      order[n] = g;
    end
    tick();
    req_valid = '0;
    wait_resp(r);
    chk("fair_0", 64'(order[0]), 64'(0));
    chk("fair_1", 64'(order[1]), 64'(1));
    chk("fair_2", 64'(order[2]), 64'(0));
    chk("fair_3", 64'(order[3]), 64'(1));
    chk("fair_searches", 64'(search_count - s0), 64'(4));
    chk("fair_hits",     64'(hit_count), 64'(5));

    // Timeout: cache never answers
    tick();
    req_addr[0 +: ADDR_W] = 32'd8;
    req_valid = 2'b01;
    delay_cfg = 0;
    wait_ready(t, g);
    chk("to_grant", 64'(g), 64'(0));
    tick();
    req_valid = '0;
    wait_resp(r);
    chk("to_resp_lat", 64'(r - t), 64'(34));
    chk("to_error",    64'(resp_error), 64'(1));
    chk("to_hit",      64'(resp_hit),   64'(0));
    chk("to_data",     resp_data,       64'd0);
    chk("to_hits",     64'(hit_count),  64'(5));
    chk("to_misses",   64'(miss_count), 64'(1));
    // Late done pulse while idle must be dropped
    tick();
    stale_done = 1'b1;
    e0 = resp_events;
    tick();
    stale_done = 1'b0;
    repeat (5) @(negedge clock);
    chk("stale_no_resp", 64'(resp_events - e0), 64'(0));
    chk("stale_hits",    64'(hit_count),  64'(5));
    chk("stale_misses",  64'(miss_count), 64'(1));
    chk("stale_error",   64'(resp_error), 64'(1));

    // Reset during WAIT
    tick();
    req_addr[0 +: ADDR_W] = 32'd4;
    req_valid = 2'b01;
    delay_cfg = 0;
    wait_ready(t, g);
    tick();
    req_valid = '0;
    repeat (3) @(negedge clock);
    e0 = resp_events;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_rv",     64'(resp_valid),    64'(0));
    chk("mid_rst_addr",   64'(cache_address), 64'(0));
    chk("mid_rst_hits",   64'(hit_count),     64'(0));
    chk("mid_rst_misses", 64'(miss_count),    64'(0));
    chk("mid_rst_error",  64'(resp_error),    64'(0));
    tick();
    tick();
    reset = 1'b1;
    tick();
    req_addr[0 +: ADDR_W]      = 32'd24;
    req_addr[ADDR_W +: ADDR_W] = 32'd40;
    req_valid = 2'b11;
    delay_cfg = 2;
    hit_cfg   = 1'b1;
    data_cfg  = 64'h77;
    wait_ready(t, g);
    chk("post_rst_grant", 64'(g), 64'(0));
    tick();
    req_valid = '0;
    wait_resp(r);
    chk("post_rst_resps", 64'(resp_events - e0), 64'(1));
    chk("post_rst_lat",   64'(r - t), 64'(4));
    chk("post_rst_rv",    64'(resp_valid), 64'(2'b01));
    chk("post_rst_data",  resp_data, 64'h77);
    chk("post_rst_hits",  64'(hit_count), 64'(1));
    chk("post_rst_addr",  64'(cache_address), 64'(24));

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
